// File: rtl/apb_reg_responder_pkg.sv
// apb_reg_responder shared types and bus widths.
// Optional wait states: define APB_REG_RESPONDER_WAIT_EN.
package apb_reg_responder_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = 4;
  localparam int WAIT_W     = 4;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

endpackage

// File: rtl/apb_reg_bank.sv
// Register bank: NREGS byte-strobed 32-bit registers,
// one write port and one combinational read port.
module apb_reg_bank
  import apb_reg_responder_pkg::*;
#(
  parameter  int NREGS = 8,
  localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        we_i,
  input  logic [IDX_W-1:0]            wr_idx_i,
  input  logic [APB_STRB_W-1:0]       strb_i,
  input  logic [APB_DATA_W-1:0]       wdata_i,
  input  logic [IDX_W-1:0]            rd_idx_i,
  output logic [APB_DATA_W-1:0]       rdata_o,
  output logic [APB_DATA_W*NREGS-1:0] regs_o
);

  logic [APB_DATA_W-1:0] regs_q [NREGS];

  // Byte-lane writes into the selected register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NREGS; k++) begin
        regs_q[k] <= '0;
      end
    end else if (we_i) begin
      for (int k = 0; k < NREGS; k++) begin
        for (int b = 0; b < APB_STRB_W; b++) begin
          if (wr_idx_i == IDX_W'(k) && strb_i[b]) begin
            regs_q[k][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end
    end
  end

  // Read mux; an index past NREGS reads as zero.
  always_comb begin
    rdata_o = '0;
    for (int k = 0; k < NREGS; k++) begin
      if (rd_idx_i == IDX_W'(k)) begin
        rdata_o = regs_q[k];
      end
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs_o[APB_DATA_W*g +: APB_DATA_W] = regs_q[g];
  end

endmodule

// File: rtl/apb_reg_responder.sv
// APB completer over a register bank with decode errors.
// Wait states enabled by APB_REG_RESPONDER_WAIT_EN.
module apb_reg_responder
  import apb_reg_responder_pkg::*;
#(
  parameter int               NREGS       = 8,
  parameter logic [31:0]      BASE_ADDR   = 32'h0000_0000,
  parameter int               WAIT_CYCLES = 2
) (
  input  logic                        apb_clk_i,
  input  logic                        apb_resetn_i,
  input  logic [APB_ADDR_W-1:0]       apb_addr_i,
  input  logic                        apb_sel_i,
  input  logic                        apb_enable_i,
  input  logic                        apb_write_i,
  input  logic [APB_STRB_W-1:0]       apb_strb_i,
  input  logic [2:0]                  apb_prot_i,
  input  logic [APB_DATA_W-1:0]       apb_wdata_i,
  output logic                        apb_ready_o,
  output logic [APB_DATA_W-1:0]       apb_rdata_o,
  output logic                        apb_slverr_o,
  output logic [APB_DATA_W*NREGS-1:0] regs_o
);

  localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [APB_ADDR_W-1:0] SPAN =
    APB_ADDR_W'(4 * NREGS);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   err_q, err_d;
  logic                   wr_q, wr_d;
  logic [APB_DATA_W-1:0]  rdata_q, rdata_d;
  logic [APB_ADDR_W-1:0]  off;
  logic [IDX_W-1:0]       idx_dec;
  logic                   err_dec;
  logic [APB_DATA_W-1:0]  bank_rdata;
  logic                   setup, access_ph;
  logic                   load, clr, we;
  logic                   unused_prot;

`ifdef APB_REG_RESPONDER_WAIT_EN
  logic [WAIT_W-1:0]      cnt_q, cnt_d;
  logic                   dec;
  assign apb_ready_o = (cnt_q == '0);
`else
  assign apb_ready_o = 1'b1;
`endif

  assign unused_prot = ^apb_prot_i;

  assign off     = apb_addr_i - BASE_ADDR;
  assign idx_dec = off[IDX_W+1:2];
  assign err_dec = (apb_addr_i < BASE_ADDR) ||
                   (off >= SPAN) ||
                   (apb_addr_i[1:0] != 2'b00);

  assign setup     = apb_sel_i & ~apb_enable_i;
  assign access_ph = apb_sel_i & apb_enable_i;

  assign we = (state_q == ACCESS) && access_ph &&
              apb_ready_o && wr_q && !err_q;

  assign apb_rdata_o  = rdata_q;
  assign apb_slverr_o = access_ph & apb_ready_o & err_q;

  apb_reg_bank #(
    .NREGS (NREGS)
  ) u_bank (
    .clk_i    (apb_clk_i),
    .rst_ni   (apb_resetn_i),
    .we_i     (we),
    .wr_idx_i (idx_q),
    .strb_i   (apb_strb_i),
    .wdata_i  (apb_wdata_i),
    .rd_idx_i (idx_dec),
    .rdata_o  (bank_rdata),
    .regs_o   (regs_o)
  );

  // State and latched transfer attributes.
  always_ff @(posedge apb_clk_i or negedge apb_resetn_i) begin
    if (!apb_resetn_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
`ifdef APB_REG_RESPONDER_WAIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
`ifdef APB_REG_RESPONDER_WAIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next state: latch on setup, clear on completion or abort.
  always_comb begin
    load    = 1'b0;
    clr     = 1'b0;
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
`ifdef APB_REG_RESPONDER_WAIT_EN
    dec     = 1'b0;
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (setup) load = 1'b1;
      end
      ACCESS: begin
        unique case (1'b1)
          !apb_sel_i:               clr  = 1'b1;
          setup:                    load = 1'b1;
          access_ph && apb_ready_o: clr  = 1'b1;
          default: begin
`ifdef APB_REG_RESPONDER_WAIT_EN
            dec = 1'b1;
`endif
          end
        endcase
      end
      default: clr = 1'b1;
    endcase
    if (load) begin
      state_d = ACCESS;
      idx_d   = idx_dec;
      err_d   = err_dec;
      wr_d    = apb_write_i;
      rdata_d = (apb_write_i || err_dec) ? '0 : bank_rdata;
`ifdef APB_REG_RESPONDER_WAIT_EN
      cnt_d   = WAIT_W'(WAIT_CYCLES);
`endif
    end
    if (clr) begin
      state_d = IDLE;
      err_d   = 1'b0;
      wr_d    = 1'b0;
      rdata_d = '0;
`ifdef APB_REG_RESPONDER_WAIT_EN
      cnt_d   = '0;
`endif
    end
`ifdef APB_REG_RESPONDER_WAIT_EN
    if (dec) cnt_d = cnt_q - 1'b1;
`endif
  end

endmodule

// File: tb/tb_apb_reg_responder.sv
// Randomized scoreboard bench for apb_reg_responder.
// Expected responses come from an array model of the map.
module tb_apb_reg_responder;

  localparam int          NREGS = 8;
  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam int          WAITC = 2;
`ifdef APB_REG_RESPONDER_WAIT_EN
  localparam int          EXP_WAIT = WAITC;
`else
  localparam int          EXP_WAIT = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       addr;
  logic              sel, en, wr;
  logic [3:0]        strb;
  logic [2:0]        prot;
  logic [31:0]       wdata;
  logic              ready;
  logic [31:0]       rdata;
  logic              slverr;
  logic [32*NREGS-1:0] regs;

  always #5 clk = ~clk;

  apb_reg_responder #(
    .NREGS       (NREGS),
    .BASE_ADDR   (BASE),
    .WAIT_CYCLES (WAITC)
  ) dut (
    .apb_clk_i    (clk),
    .apb_resetn_i (rst_n),
    .apb_addr_i   (addr),
    .apb_sel_i    (sel),
    .apb_enable_i (en),
    .apb_write_i  (wr),
    .apb_strb_i   (strb),
    .apb_prot_i   (prot),
    .apb_wdata_i  (wdata),
    .apb_ready_o  (ready),
    .apb_rdata_o  (rdata),
    .apb_slverr_o (slverr),
    .regs_o       (regs)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          waits;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int          wc = 0;
  logic [31:0] mem [NREGS];

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_regs(string tag);
    for (int k = 0; k < NREGS; k++) begin
      chk($sformatf("%s reg%0d", tag, k), regs[32*k +: 32],
          mem[k]);
    end
  endtask

  // Reference map: range/alignment rule, byte-lane merge.
  function automatic exp_t model(logic [31:0] a, logic w,
                                 logic [3:0] s,
                                 logic [31:0] d);
    exp_t   e;
    longint la  = longint'(a);
    longint lb  = longint'(BASE);
    int     idx;
    e.waits = EXP_WAIT;
    e.err   = (la < lb) || (la >= lb + 4 * NREGS) ||
              (a % 4 != 0);
    e.rdata = 32'h0;
    if (!e.err) begin
      idx = int'((la - lb) / 4);
      if (w) begin
        for (int b = 0; b < 4; b++) begin
          if (s[b]) mem[idx][8*b +: 8] = d[8*b +: 8];
        end
      end else begin
        e.rdata = mem[idx];
      end
    end
    return e;
  endfunction

  // Monitor: compare each completing access cycle.
  always @(negedge clk) begin
    if (!rst_n || !(sel && en)) begin
      wc = 0;
    end else if (!ready) begin
      wc++;
      chk("slverr while waiting", 32'(slverr), 32'h0);
    end else begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected completion at %0t", $time);
      end else begin
        mon_e = sbq.pop_front();
        chk("rdata", rdata, mon_e.rdata);
        chk("slverr", 32'(slverr), 32'(mon_e.err));
        chk("wait cycles", 32'(wc), 32'(mon_e.waits));
      end
      wc = 0;
    end
  end

  // Drives one transfer starting now (just after an edge).
  task automatic xfer(logic [31:0] a, logic w,
                      logic [3:0] s, logic [31:0] d);
    bit done = 0;
    int n = 0;
    sbq.push_back(model(a, w, s, d));
    addr = a; wr = w; strb = s; wdata = d;
    sel = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    en = 1'b1;
    while (!done && n < 40) begin
      @(negedge clk);
      if (ready) done = 1;
      @(posedge clk); #1;
      n++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL timeout: ready stayed %b want 1", ready);
    end
    chk("post ready", 32'(ready), 32'h1);
    chk("post rdata", rdata, 32'h0);
    chk("post slverr", 32'(slverr), 32'h0);
    chk_regs("post");
  endtask

  task automatic idle();
    sel = 1'b0; en = 1'b0; wr = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: sim time %0t exceeded", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          r;
    for (int k = 0; k < NREGS; k++) mem[k] = '0;
    rst_n = 1'b0; sel = 1'b0; en = 1'b0; wr = 1'b0;
    addr = '0; strb = '0; wdata = '0; prot = 3'b010;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", 32'(ready), 32'h1);
    chk("reset rdata", rdata, 32'h0);
    chk("reset slverr", 32'(slverr), 32'h0);
    chk_regs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    xfer(BASE + 32'h4, 1'b1, 4'hF, 32'hDEAD_BEEF);
    idle();
    xfer(BASE + 32'h4, 1'b0, 4'h0, 32'h0);
    chk("tp1 reg1", regs[63:32], 32'hDEAD_BEEF);
    xfer(BASE + 32'h4, 1'b1, 4'b0101, 32'h1122_3344);
    xfer(BASE + 32'h4, 1'b0, 4'h0, 32'h0);
    chk("tp2 reg1", regs[63:32], 32'hDE22_BE44);
    idle();
    xfer(BASE + 32'(4 * NREGS), 1'b0, 4'h0, 32'h0);
    xfer(BASE + 32'h2, 1'b1, 4'hF, 32'hFFFF_FFFF);
    xfer(BASE - 32'h4, 1'b1, 4'hF, 32'hFFFF_FFFF);
    xfer(BASE, 1'b1, 4'hF, 32'h0BAD_F00D);
    xfer(BASE + 32'h8, 1'b1, 4'h0, 32'h5555_5555);
    idle();

    // Abort: sel drops during the access phase.
    addr = BASE; wr = 1'b1; strb = 4'hF;
    wdata = 32'hA5A5_A5A5; sel = 1'b1; en = 1'b0;
    @(posedge clk); #1;
`ifdef APB_REG_RESPONDER_WAIT_EN
    en = 1'b1;
    @(posedge clk); #1;
`endif
    sel = 1'b0; en = 1'b0;
    @(posedge clk); #1;
    chk("abort ready", 32'(ready), 32'h1);
    chk("abort rdata", rdata, 32'h0);
    chk("abort slverr", 32'(slverr), 32'h0);
    chk("abort reg0", regs[31:0], 32'h0BAD_F00D);
    chk_regs("abort");
    xfer(BASE, 1'b0, 4'h0, 32'h0);
    idle();

    // Reset in the middle of a write.
    addr = BASE + 32'h8; wr = 1'b1; strb = 4'hF;
    wdata = 32'h1234_5678; sel = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    en = 1'b1;
    #1;
    rst_n = 1'b0; sel = 1'b0; en = 1'b0;
    #1;
    for (int k = 0; k < NREGS; k++) mem[k] = '0;
    chk("rst ready", 32'(ready), 32'h1);
    chk("rst rdata", rdata, 32'h0);
    chk("rst slverr", 32'(slverr), 32'h0);
    chk_regs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_regs("after rst");

    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 11);
      if (r <= 6)
        a = BASE + 32'(4 * $urandom_range(0, NREGS - 1));
      else if (r == 7)
        a = BASE + 32'(4 * $urandom_range(0, NREGS - 1)) +
            32'($urandom_range(1, 3));
      else if (r == 8)
        a = BASE + 32'(4 * NREGS) +
            32'(4 * $urandom_range(0, 15));
      else if (r == 9)
        a = BASE - 32'(4 * $urandom_range(1, 8));
      else
        a = $urandom;
      xfer(a, 1'($urandom_range(0, 1)), 4'($urandom),
           $urandom);
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();
    idle();
    chk("scoreboard drained", 32'(sbq.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
